// File: rtl/mul_man_arb_if.sv
// Bundle between the lane front ends, the shared multiplier and the response consumer.
// The master side drives requests, mul_result and rsp_ready. The slave side is mul_man_arb.
interface mul_man_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 12,
    parameter int RES_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_op1;
    logic [NUM_REQ*OP_W-1:0] req_op2;
    logic [OP_W-1:0]         mul_op1;
    logic [OP_W-1:0]         mul_op2;
    logic [RES_W-1:0]        mul_result;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [RES_W-1:0]        rsp_result;

    modport master (
        output req_valid, req_op1, req_op2, mul_result, rsp_ready,
        input  req_ready, mul_op1, mul_op2, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_op1, req_op2, mul_result, rsp_ready,
        output req_ready, mul_op1, mul_op2, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/mul_man_arb.sv
// Round-robin share of one fixed-latency mantissa multiplier among NUM_REQ lanes.
// The design tracks in-flight tags and uses a credit-protected response FIFO.
// Ports: clk, rst (async, active-high), bus (mul_man_arb_if.slave: req_*, mul_*, rsp_*).
// Optional feature: MUL_ARB_STATS_EN adds stat_issue / stat_stall (32b, saturating).
module mul_man_arb #(
    parameter int NUM_REQ   = 4,
    parameter int OP_W      = 12,
    parameter int RES_W     = 16,
    parameter int MUL_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MUL_ARB_STATS_EN
    output logic [31:0] stat_issue,
    output logic [31:0] stat_stall,
`endif
    mul_man_arb_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int AW   = $clog2(RSP_DEPTH);
    localparam int CW   = $clog2(RSP_DEPTH + MUL_LAT + 2);

    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              gnt_id;
    logic [ID_W-1:0]              cand;
    logic                         gnt;
    logic [NUM_REQ-1:0]           ready;
    logic [OP_W-1:0]              sel_op1;
    logic [OP_W-1:0]              sel_op2;
    logic [MUL_LAT:0]             tag_v;
    logic [MUL_LAT:0][ID_W-1:0]   tag_id;
    logic [CW-1:0]                inflight;
    logic [CW-1:0]                fifo_cnt;
    logic                         credit;
    logic [ID_W-1:0]              mem_id  [RSP_DEPTH];
    logic [RES_W-1:0]             mem_res [RSP_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         rsp_v;

    // Every granted product occupies a slot from grant until it is popped.
    // A pop in the current cycle is not credited back.
    always_comb begin
        inflight = '0;
        for (int s = 0; s <= MUL_LAT; s++) begin
            inflight = inflight + CW'(tag_v[s]);
        end
    end

    assign credit = (fifo_cnt + inflight) < CW'(RSP_DEPTH);

    // The arbiter picks the first valid requester at or after rr_ptr.
    always_comb begin
        gnt    = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(rr_ptr) + k >= NUM_REQ) begin
                cand = ID_W'(int'(rr_ptr) + k - NUM_REQ);
            end else begin
                cand = ID_W'(int'(rr_ptr) + k);
            end
            if (credit && !rst && !gnt && bus.req_valid[cand]) begin
                gnt    = 1'b1;
                gnt_id = cand;
            end
        end
    end

    always_comb begin
        ready   = '0;
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt && gnt_id == ID_W'(i)) begin
                ready[i] = 1'b1;
                sel_op1  = bus.req_op1[i*OP_W +: OP_W];
                sel_op2  = bus.req_op2[i*OP_W +: OP_W];
            end
        end
    end

    assign bus.req_ready = ready;

    assign push  = tag_v[MUL_LAT];
    assign full  = (fifo_cnt == CW'(RSP_DEPTH));
    assign rsp_v = (fifo_cnt != '0);
    assign pop   = rsp_v & bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            bus.mul_op1 <= '0;
            bus.mul_op2 <= '0;
            tag_v       <= '0;
            tag_id      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
        end else begin
            if (gnt) begin
                rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            end
            bus.mul_op1 <= sel_op1;
            bus.mul_op2 <= sel_op2;
            tag_v       <= {tag_v[MUL_LAT-1:0], gnt};
            tag_id      <= {tag_id[MUL_LAT-1:0], gnt_id};
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end
        end
    end

    // The storage array needs no reset because the outputs are gated by rsp_v.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]  <= tag_id[MUL_LAT];
            mem_res[wr_ptr] <= bus.mul_result;
        end
    end

    assign bus.rsp_valid  = rsp_v;
    assign bus.rsp_id     = rsp_v ? mem_id[rd_ptr]  : '0;
    assign bus.rsp_result = rsp_v ? mem_res[rd_ptr] : '0;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && full && !pop)
    );

`ifdef MUL_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (gnt && stat_issue != '1) begin
                stat_issue <= stat_issue + 32'd1;
            end
            if (|bus.req_valid && !gnt && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
